// File: rtl/fwrisc_miter_timing_monitor.sv
// fwrisc_miter_timing_monitor
// Watches the request side of both miter cores and latches a sticky verdict
// on the first cycle in which fetch/data request timing, addresses, write
// attributes or (optionally) write data differ between the two cores. Also
// flags any asymmetry in the environment's ready handshakes.
module fwrisc_miter_timing_monitor #(
   parameter int CNT_W      = 16,
   parameter int MAX_CYCLES = 1000,
   parameter int CMP_WDATA  = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [31:0]      iaddr1,
   input  logic [31:0]      iaddr2,
   input  logic             ivalid1,
   input  logic             ivalid2,
   input  logic             iready1,
   input  logic             iready2,
   input  logic [31:0]      daddr1,
   input  logic [31:0]      daddr2,
   input  logic             dvalid1,
   input  logic             dvalid2,
   input  logic             dwrite1,
   input  logic             dwrite2,
   input  logic [3:0]       dwstb1,
   input  logic [3:0]       dwstb2,
   input  logic [31:0]      dwdata1,
   input  logic [31:0]      dwdata2,
   input  logic             dready1,
   input  logic             dready2,
   output logic             busy,
   output logic             done,
   output logic             diverged,
   output logic [5:0]       cause,
   output logic [CNT_W-1:0] div_cycle,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] txn_cnt,
   output logic             env_violation
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_MONITOR  = 2'd1,
      S_DIVERGED = 2'd2,
      S_DONE     = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(MAX_CYCLES - 1);
   localparam logic             WDATA_EN   = (CMP_WDATA != 0);

   state_t     state;
   logic [5:0] m;
   logic [1:0] txn_inc;
   logic       env_mis;
   logic       in_mon;
   logic       launch;

   // Saturating counter add: clamps at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [1:0]       b);
      logic [CNT_W:0] s;
      s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
      return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
   endfunction

   assign in_mon = (state == S_MONITOR);
   // start is honoured only outside an active window
   assign launch = start && !in_mon;

   // Per-cycle mismatch vector; fields gated by their valids so idle buses never diverge
   always_comb begin
      m = 6'b0;
      if (in_mon) begin
         m[0] = ivalid1 != ivalid2;
         m[1] = ivalid1 & ivalid2 & (iaddr1 != iaddr2);
         m[2] = dvalid1 != dvalid2;
         m[3] = dvalid1 & dvalid2 & (daddr1 != daddr2);
         m[4] = dvalid1 & dvalid2 & ((dwrite1 != dwrite2) | (dwstb1 != dwstb2));
         m[5] = WDATA_EN & dvalid1 & dvalid2 & dwrite1 & dwrite2 & (dwdata1 != dwdata2);
      end
   end

   // Completed core-1 handshakes this cycle (fetch and data may both complete)
   always_comb begin
      txn_inc = {1'b0, ivalid1 & iready1} + {1'b0, dvalid1 & dready1};
      env_mis = (iready1 != iready2) | (dready1 != dready2);
   end

   // Window FSM with registered one-hot status flags and first-divergence capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         diverged  <= 1'b0;
         cause     <= 6'b0;
         div_cycle <= '0;
      end else begin
         case (state)
            S_MONITOR: begin
               if (m != 6'b0) begin
                  state     <= S_DIVERGED;
                  busy      <= 1'b0;
                  diverged  <= 1'b1;
                  cause     <= m;
                  div_cycle <= cycle_cnt;
               end else if (cycle_cnt == LAST_CYCLE) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: begin
               if (start) begin
                  state     <= S_MONITOR;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  diverged  <= 1'b0;
                  cause     <= 6'b0;
                  div_cycle <= '0;
               end
            end
         endcase
      end
   end

   // Window counters run only while monitoring and freeze on a verdict
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_cnt <= '0;
         txn_cnt   <= '0;
      end else if (launch) begin
         cycle_cnt <= '0;
         txn_cnt   <= '0;
      end else if (in_mon) begin
         cycle_cnt <= sat_add(cycle_cnt, 2'd1);
         txn_cnt   <= sat_add(txn_cnt, txn_inc);
      end
   end

   // Sticky environment-symmetry flag, independent of the divergence verdict
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         env_violation <= 1'b0;
      end else if (launch) begin
         env_violation <= 1'b0;
      end else if (in_mon && env_mis) begin
         env_violation <= 1'b1;
      end
   end

endmodule
